// File: rtl/nv_ram_rws_param.sv
// Parametrised 1R1W synchronous RAM with optional output register, read-valid strobe
// and out-of-range protection. Define NV_RAM_RWS_BYPASS_EN for write-first output capture.
module nv_ram_rws_param #(
   parameter int WIDTH   = 18,
   parameter int DEPTH   = 128,
   parameter int AW      = $clog2(DEPTH),
   parameter int OUT_REG = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [AW-1:0]    ra,
   input  logic             re,
   output logic [WIDTH-1:0] dout,
   output logic             dout_vld,
   input  logic [AW-1:0]    wa,
   input  logic             we,
   input  logic [WIDTH-1:0] di,
   input  logic [31:0]      pwrbus_ram_pd
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    ra_d;
   logic             oor_d;
   logic             vld_d1;
   logic             wa_ok;
   logic             ra_oor;
   logic [WIDTH-1:0] rd_word;
   logic             unused_pwr;

   // Compare at 32 bits so a power-of-two DEPTH never wraps the bound.
   assign wa_ok  = 32'(wa) < DEPTH;
   assign ra_oor = 32'(ra) >= DEPTH;

   assign unused_pwr = ^pwrbus_ram_pd;

   always_ff @(posedge clk) begin
      if (we && wa_ok) mem[wa] <= di;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ra_d   <= '0;
         oor_d  <= 1'b0;
         vld_d1 <= 1'b0;
      end else begin
         vld_d1 <= re;
         if (re) begin
            ra_d  <= ra;
            oor_d <= ra_oor;
         end
      end
   end

   assign rd_word = oor_d ? '0 : mem[ra_d];

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic             vld_d2;
         logic [WIDTH-1:0] dout_q;
         logic [WIDTH-1:0] dout_nxt;

`ifdef NV_RAM_RWS_BYPASS_EN
         // A write landing on the address being captured wins over the stale array word.
         assign dout_nxt = (we && (wa == ra_d) && !oor_d) ? di : rd_word;
`else
         assign dout_nxt = rd_word;
`endif

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               vld_d2 <= 1'b0;
               dout_q <= '0;
            end else begin
               vld_d2 <= vld_d1;
               if (vld_d1) dout_q <= dout_nxt;
            end
         end

         assign dout     = dout_q;
         assign dout_vld = vld_d2;
      end else begin : g_comb
         assign dout     = rd_word;
         assign dout_vld = vld_d1;
      end
   endgenerate

endmodule
